// File: rtl/usbdev_pkg.sv
// USB device remote-wakeup shared types and default timing constants.
// Times are in microseconds, counted against the 1 us strobe.
package usbdev_pkg;

  typedef enum logic [2:0] {
    WAKE_IDLE    = 3'd0,
    WAKE_WAITAGE = 3'd1,
    WAKE_DRIVEK  = 3'd2,
    WAKE_RELEASE = 3'd3
  } wake_state_e;

  localparam int unsigned USB_SUSPEND_MIN_US  = 5000;
  localparam int unsigned USB_RESUME_DRIVE_US = 2000;
  localparam int unsigned USB_HOST_RESP_US    = 30000;

endpackage

// File: rtl/usbdev_wake_seq_if.sv
// Link-status / wakeup-control bundle between the device core and the
// wakeup sequencer; master drives requests and link status.
interface usbdev_wake_seq_if;

  logic       us_tick_i;
  logic       wake_en_i;
  logic       wake_req_i;
  logic       link_suspend_i;
  logic       link_active_i;
  logic       link_reset_i;
  logic       link_disconnect_i;
  logic       drive_k_o;
  logic       resume_link_active_o;
  logic       wake_busy_o;
  logic       wake_done_o;
  logic       wake_err_o;
  logic [2:0] wake_state_o;

  modport master (
    output us_tick_i, wake_en_i, wake_req_i,
    output link_suspend_i, link_active_i,
    output link_reset_i, link_disconnect_i,
    input  drive_k_o, resume_link_active_o,
    input  wake_busy_o, wake_done_o, wake_err_o,
    input  wake_state_o
  );

  modport slave (
    input  us_tick_i, wake_en_i, wake_req_i,
    input  link_suspend_i, link_active_i,
    input  link_reset_i, link_disconnect_i,
    output drive_k_o, resume_link_active_o,
    output wake_busy_o, wake_done_o, wake_err_o,
    output wake_state_o
  );

endinterface

// File: rtl/usbdev_us_timer.sv
// Microsecond counter: synchronous clear, counts on the us strobe and
// holds at Max instead of wrapping.
module usbdev_us_timer #(
  parameter int unsigned W   = 15,
  parameter int unsigned Max = (2**W) - 1
) (
  input  logic         clk_48mhz_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         tick_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MaxV = W'(Max);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (tick_i && (r_cnt != MaxV)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/usbdev_wake_seq.sv
// Remote-wakeup sequencer: waits for a settled suspend, drives K for a
// fixed time, then hands the bus back and watches for the host resume.
module usbdev_wake_seq
  import usbdev_pkg::*;
#(
  parameter int unsigned SuspendMinUs  = USB_SUSPEND_MIN_US,
  parameter int unsigned ResumeDriveUs = USB_RESUME_DRIVE_US,
  parameter int unsigned HostRespUs    = USB_HOST_RESP_US,
  parameter int unsigned TimerW        = 15
) (
  input logic         clk_48mhz_i,
  input logic         rst_ni,
  usbdev_wake_seq_if.slave bus
);

  localparam logic [TimerW-1:0] AgeMax    = TimerW'(SuspendMinUs);
  localparam logic [TimerW-1:0] DriveLast = TimerW'(ResumeDriveUs - 1);
  localparam logic [TimerW-1:0] RespLast  = TimerW'(HostRespUs - 1);

  wake_state_e       r_state;
  logic              r_drive_k;
  logic              r_resume;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  wake_state_e       w_next;
  logic              w_done;
  logic              w_err;
  logic              w_resume;
  logic              w_abort;
  logic              w_age_ok;
  logic              w_phase_clr;
  logic [TimerW-1:0] w_age;
  logic [TimerW-1:0] w_phase;

  usbdev_us_timer #(
    .W   (TimerW),
    .Max (SuspendMinUs)
  ) u_age (
    .clk_48mhz_i (clk_48mhz_i),
    .rst_ni      (rst_ni),
    .clr_i       (!bus.link_suspend_i),
    .tick_i      (bus.us_tick_i),
    .cnt_o       (w_age)
  );

  usbdev_us_timer #(
    .W (TimerW)
  ) u_phase (
    .clk_48mhz_i (clk_48mhz_i),
    .rst_ni      (rst_ni),
    .clr_i       (w_phase_clr),
    .tick_i      (bus.us_tick_i),
    .cnt_o       (w_phase)
  );

  assign w_age_ok    = (w_age == AgeMax);
  assign w_abort     = bus.link_reset_i | bus.link_disconnect_i;
  assign w_phase_clr = (w_next != r_state);

  always_comb begin
    w_next   = r_state;
    w_done   = 1'b0;
    w_err    = 1'b0;
    w_resume = 1'b0;
    unique case (r_state)
      WAKE_IDLE: begin
        if (bus.wake_req_i) begin
          if (bus.wake_en_i && bus.link_suspend_i) begin
            w_next = WAKE_WAITAGE;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      WAKE_WAITAGE: begin
        if (w_abort || !bus.link_suspend_i) begin
          w_next = WAKE_IDLE;
          w_err  = 1'b1;
        end else if (w_age_ok) begin
          w_next = WAKE_DRIVEK;
        end
      end
      // Suspend dropping here is our own K on the line, not an abort.
      WAKE_DRIVEK: begin
        if (w_abort) begin
          w_next = WAKE_IDLE;
          w_err  = 1'b1;
        end else if (bus.us_tick_i && (w_phase == DriveLast)) begin
          w_next   = WAKE_RELEASE;
          w_resume = 1'b1;
        end
      end
      WAKE_RELEASE: begin
        if (w_abort) begin
          w_next = WAKE_IDLE;
          w_err  = 1'b1;
        end else if (bus.us_tick_i && (w_phase == RespLast)) begin
          w_next = WAKE_IDLE;
          w_err  = 1'b1;
        end else if (bus.link_active_i) begin
          w_next = WAKE_IDLE;
          w_done = 1'b1;
        end
      end
      default: begin
        w_next = WAKE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= WAKE_IDLE;
      r_drive_k <= 1'b0;
      r_resume  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_drive_k <= (w_next == WAKE_DRIVEK);
      r_resume  <= w_resume;
      r_busy    <= (w_next != WAKE_IDLE);
      r_done    <= w_done;
      r_err     <= w_err;
    end
  end

  assign bus.drive_k_o            = r_drive_k;
  assign bus.resume_link_active_o = r_resume;
  assign bus.wake_busy_o          = r_busy;
  assign bus.wake_done_o          = r_done;
  assign bus.wake_err_o           = r_err;
  assign bus.wake_state_o         = r_state;

  a_state_legal: assert property (
    @(posedge clk_48mhz_i) disable iff (!rst_ni)
    r_state inside {WAKE_IDLE, WAKE_WAITAGE, WAKE_DRIVEK, WAKE_RELEASE}
  );

  a_k_in_drive: assert property (
    @(posedge clk_48mhz_i) disable iff (!rst_ni)
    r_drive_k |-> (r_state == WAKE_DRIVEK)
  );

  a_done_err_excl: assert property (
    @(posedge clk_48mhz_i) disable iff (!rst_ni)
    !(r_done && r_err)
  );

endmodule

// File: tb/tb_usbdev_wake_seq.sv
// Bench for usbdev_wake_seq: reject table, directed multi-cycle
// sequences, then random stimulus against a behavioural model.
module tb_usbdev_wake_seq;

  localparam int SMIN = 50;
  localparam int RD   = 20;
  localparam int HR   = 100;

  typedef struct {
    bit en;
    bit susp;
    bit disc;
    int exp_state;
    bit exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  usbdev_wake_seq_if vif ();

  usbdev_wake_seq #(
    .SuspendMinUs  (SMIN),
    .ResumeDriveUs (RD),
    .HostRespUs    (HR),
    .TimerW        (15)
  ) dut (
    .clk_48mhz_i (clk),
    .rst_ni      (rst_ni),
    .bus         (vif)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_tick = 0;
  bit mdl_on = 0;
  int k_ticks, rel_ticks, age_ticks, res_cnt, done_cnt, err_cnt;
  int m_state, m_age, m_ph;
  bit e_res, e_done, e_err;
  vec_t tbl[6];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({vif.drive_k_o, vif.resume_link_active_o,
                 vif.wake_busy_o, vif.wake_done_o,
                 vif.wake_err_o, vif.wake_state_o});
  endfunction

  task automatic clear_cnts();
    k_ticks = 0; rel_ticks = 0;
    res_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  // Reference: spec rules stepped once per clock on the sampled inputs.
  task automatic model_step();
    bit tk, ab, ok;
    int nx;
    tk = vif.us_tick_i;
    ab = vif.link_reset_i | vif.link_disconnect_i;
    ok = (m_age >= SMIN);
    nx = m_state;
    e_res = 0; e_done = 0; e_err = 0;
    case (m_state)
      0: if (vif.wake_req_i) begin
           if (vif.wake_en_i && vif.link_suspend_i) nx = 1;
           else e_err = 1;
         end
      1: if (ab || !vif.link_suspend_i) begin nx = 0; e_err = 1; end
         else if (ok) nx = 2;
      2: if (ab) begin nx = 0; e_err = 1; end
         else if (tk && (m_ph + 1 == RD)) begin nx = 3; e_res = 1; end
      3: if (ab) begin nx = 0; e_err = 1; end
         else if (tk && (m_ph + 1 == HR)) begin nx = 0; e_err = 1; end
         else if (vif.link_active_i) begin nx = 0; e_done = 1; end
      default: nx = 0;
    endcase
    m_ph = (nx != m_state) ? 0 : m_ph + int'(tk);
    if (!vif.link_suspend_i) m_age = 0;
    else if (m_age < 1000000) m_age = m_age + int'(tk);
    m_state = nx;
  endtask

  task automatic check_model();
    logic [7:0] ex;
    logic [2:0] st;
    st = 3'(m_state);
    ex = {m_state == 2, e_res, m_state != 0, e_done, e_err, st};
    chk($sformatf("model@%0d", cyc), outs(), int'(ex));
  endtask

  task automatic clk1();
    cyc++;
    vif.us_tick_i = rnd_tick ? ($urandom_range(0, 2) == 0) : (cyc % 4 == 0);
    if (vif.drive_k_o && vif.us_tick_i) k_ticks++;
    if (vif.wake_state_o == 3'd3 && vif.us_tick_i) rel_ticks++;
    age_ticks = vif.link_suspend_i ? age_ticks + int'(vif.us_tick_i) : 0;
    @(posedge clk);
    if (mdl_on) model_step();
    #1;
    if (vif.resume_link_active_o) res_cnt++;
    if (vif.wake_done_o) done_cnt++;
    if (vif.wake_err_o) err_cnt++;
    if (mdl_on) check_model();
  endtask

  task automatic pulse_req();
    vif.wake_req_i = 1;
    clk1();
    vif.wake_req_i = 0;
  endtask

  task automatic wait_k_rise(string name, int budget);
    for (int i = 0; i < budget && !vif.drive_k_o; i++) clk1();
    chk(name, int'(vif.drive_k_o), 1);
  endtask

  task automatic wait_k_fall(string name, int budget);
    for (int i = 0; i < budget && vif.drive_k_o; i++) clk1();
    chk(name, int'(vif.drive_k_o), 0);
  endtask

  initial begin
    tbl = '{
      '{0, 0, 0, 0, 1},
      '{0, 1, 0, 0, 1},
      '{1, 0, 0, 0, 1},
      '{1, 1, 0, 1, 0},
      '{1, 1, 1, 1, 0},
      '{0, 1, 1, 0, 1}
    };
    vif.us_tick_i = 0; vif.wake_en_i = 0; vif.wake_req_i = 0;
    vif.link_suspend_i = 0; vif.link_active_i = 0;
    vif.link_reset_i = 0; vif.link_disconnect_i = 0;
    age_ticks = 0;
    clear_cnts();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 0);
    rst_ni = 1;

    foreach (tbl[i]) begin
      vif.wake_en_i = tbl[i].en;
      vif.link_suspend_i = tbl[i].susp;
      clk1();
      pulse_req();
      chk($sformatf("tbl%0d_state", i), int'(vif.wake_state_o), tbl[i].exp_state);
      chk($sformatf("tbl%0d_err", i), int'(vif.wake_err_o), int'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_k", i), int'(vif.drive_k_o), 0);
      if (tbl[i].exp_state != 0) begin
        if (tbl[i].disc) vif.link_disconnect_i = 1;
        else vif.link_reset_i = 1;
        clk1();
        vif.link_disconnect_i = 0;
        vif.link_reset_i = 0;
        chk($sformatf("tbl%0d_abort_st", i), int'(vif.wake_state_o), 0);
        chk($sformatf("tbl%0d_abort_err", i), int'(vif.wake_err_o), 1);
      end
      vif.link_suspend_i = 0;
      clk1();
    end

    // Nominal: aged suspend, K burst, host resumes 10 us after release.
    vif.wake_en_i = 1;
    vif.link_suspend_i = 1;
    repeat (240) clk1();
    clear_cnts();
    pulse_req();
    wait_k_rise("nom_k_rise", 10);
    vif.link_suspend_i = 0;
    wait_k_fall("nom_k_fall", 200);
    chk("nom_k_ticks", k_ticks, RD);
    chk("nom_resume", res_cnt, 1);
    chk("nom_release", int'(vif.wake_state_o), 3);
    repeat (40) clk1();
    vif.link_active_i = 1;
    for (int i = 0; i < 5 && vif.wake_busy_o; i++) clk1();
    vif.link_active_i = 0;
    chk("nom_done", done_cnt, 1);
    chk("nom_no_err", err_cnt, 0);
    chk("nom_busy", int'(vif.wake_busy_o), 0);
    chk("nom_state", int'(vif.wake_state_o), 0);

    // Early request at age 10 us, then host never answers.
    clk1();
    vif.link_suspend_i = 1;
    for (int i = 0; i < 400 && age_ticks < 10; i++) clk1();
    clear_cnts();
    pulse_req();
    wait_k_rise("early_k_rise", 400);
    chk("early_age", age_ticks, SMIN);
    wait_k_fall("early_k_fall", 200);
    chk("early_k_ticks", k_ticks, RD);
    for (int i = 0; i < 600 && vif.wake_busy_o; i++) clk1();
    chk("tmo_rel_ticks", rel_ticks, HR);
    chk("tmo_err", err_cnt, 1);
    chk("tmo_no_done", done_cnt, 0);
    chk("tmo_state", int'(vif.wake_state_o), 0);

    // Bus reset at K tick 7.
    clear_cnts();
    pulse_req();
    wait_k_rise("abort_k_rise", 10);
    for (int i = 0; i < 200 && k_ticks < 7; i++) clk1();
    vif.link_reset_i = 1;
    clk1();
    vif.link_reset_i = 0;
    chk("abort_k_low", int'(vif.drive_k_o), 0);
    chk("abort_err", int'(vif.wake_err_o), 1);
    chk("abort_state", int'(vif.wake_state_o), 0);
    clk1();
    chk("abort_err_1cyc", int'(vif.wake_err_o), 0);
    chk("abort_no_resume", res_cnt, 0);

    // Second request while busy, then async reset mid-release.
    clear_cnts();
    pulse_req();
    wait_k_rise("busy_k_rise", 10);
    repeat (12) clk1();
    pulse_req();
    wait_k_fall("busy_k_fall", 200);
    chk("busy_k_ticks", k_ticks, RD);
    chk("busy_resume", res_cnt, 1);
    chk("busy_no_err", err_cnt, 0);
    repeat (8) clk1();
    chk("busy_release", int'(vif.wake_state_o), 3);
    #2 rst_ni = 0;
    #1 chk("async_rst_outs", outs(), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_outs", outs(), 0);
    rst_ni = 1;

    // Random stimulus against the model.
    m_state = 0; m_age = 0; m_ph = 0;
    vif.link_suspend_i = 1;
    vif.wake_en_i = 1;
    rnd_tick = 1;
    mdl_on = 1;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 799) == 0) vif.link_suspend_i = !vif.link_suspend_i;
      if ($urandom_range(0, 1999) == 0) vif.wake_en_i = !vif.wake_en_i;
      vif.wake_req_i = ($urandom_range(0, 39) == 0);
      vif.link_active_i = ($urandom_range(0, 149) == 0);
      vif.link_reset_i = ($urandom_range(0, 1499) == 0);
      vif.link_disconnect_i = ($urandom_range(0, 2999) == 0);
      clk1();
    end
    mdl_on = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
